// File: rtl/sd_block_scheduler_if.sv
// Signal bundle between the block scheduler and one SD card SPI block controller.
// The scheduler drives execute/op/address/outgoing byte; the controller drives status and read data.
interface sd_block_scheduler_if;
    logic        ctrl_ready;
    logic        ctrl_busy;
    logic        ctrl_finished_byte;
    logic        ctrl_finished_block;
    logic [7:0]  ctrl_incoming_byte;
    logic        ctrl_execute;
    logic        ctrl_op_code;
    logic [31:0] ctrl_block_address;
    logic [7:0]  ctrl_outgoing_byte;

    modport master (
        input  ctrl_ready, ctrl_busy, ctrl_finished_byte, ctrl_finished_block, ctrl_incoming_byte,
        output ctrl_execute, ctrl_op_code, ctrl_block_address, ctrl_outgoing_byte
    );

    modport slave (
        output ctrl_ready, ctrl_busy, ctrl_finished_byte, ctrl_finished_block, ctrl_incoming_byte,
        input  ctrl_execute, ctrl_op_code, ctrl_block_address, ctrl_outgoing_byte
    );
endinterface

// File: rtl/sd_block_scheduler.sv
// Round-robin scheduler sharing one SD block controller among NUM_REQ requesters:
// latches the winner's op/address, issues one execute pulse, routes byte strobes, watchdogs progress.
module sd_block_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int BLOCK_BYTES    = 512,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_op,
    input  logic [32*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rd_valid,
    output logic [7:0]              rd_data,
    output logic [NUM_REQ-1:0]      wr_ack,
    output logic [NUM_REQ-1:0]      done,
    output logic [NUM_REQ-1:0]      err,
    output logic [CNT_W-1:0]        xfer_count,
    sd_block_scheduler_if.master    ctrl
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, DONE, ERR, DRAIN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  last;
    logic [CNT_W-1:0]  byte_cnt;
    logic [WD_W-1:0]   wd;
    logic              op_q;
    logic [31:0]       addr_q;
    logic              execute_q;

    logic [IDX_W-1:0]  pick;
    logic              pick_op;
    logic [31:0]       pick_addr;
    logic [WD_W-1:0]   wd_inc;
    logic [7:0]        outgoing;

    // First pending requester after the previous owner, wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [IDX_W-1:0]   prev);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               j;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(prev) + k) % NUM_REQ;
            if (!found && r[j[IDX_W-1:0]]) begin
                sel   = j[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] w);
        return (w == WD_MAX) ? w : w + WD_W'(1);
    endfunction

    always_comb begin
        pick      = rr_pick(req, last);
        pick_op   = 1'b0;
        pick_addr = '0;
        outgoing  = '0;
        wd_inc    = sat_inc(wd);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                pick_op   = req_op[i];
                pick_addr = req_addr[32*i +: 32];
            end
            if (gnt[i]) outgoing = outgoing | req_wdata[8*i +: 8];
        end
    end

    assign ctrl.ctrl_execute       = execute_q;
    assign ctrl.ctrl_op_code       = op_q;
    assign ctrl.ctrl_block_address = addr_q;
    assign ctrl.ctrl_outgoing_byte = outgoing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last       <= IDX_W'(NUM_REQ - 1);
            gnt        <= '0;
            rd_valid   <= '0;
            wr_ack     <= '0;
            done       <= '0;
            err        <= '0;
            rd_data    <= '0;
            xfer_count <= '0;
            byte_cnt   <= '0;
            wd         <= '0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            execute_q  <= 1'b0;
        end else begin
            rd_valid  <= '0;
            wr_ack    <= '0;
            done      <= '0;
            err       <= '0;
            execute_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctrl.ctrl_ready && |req) begin
                        last      <= pick;
                        op_q      <= pick_op;
                        addr_q    <= pick_addr;
                        gnt       <= NUM_REQ'(1) << pick;
                        byte_cnt  <= '0;
                        wd        <= '0;
                        execute_q <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd    <= wd_inc;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    wd <= wd_inc;
                    if (ctrl.ctrl_busy) begin
                        state <= XFER;
                    end else if (wd_inc == WD_MAX) begin
                        err   <= gnt;
                        state <= ERR;
                    end
                end
                XFER: begin
                    // A coincident block-end still counts and forwards the byte first.
                    if (ctrl.ctrl_finished_byte) begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                        wd       <= '0;
                        if (op_q) begin
                            wr_ack <= gnt;
                        end else begin
                            rd_data  <= ctrl.ctrl_incoming_byte;
                            rd_valid <= gnt;
                        end
                        if (byte_cnt == LAST_BYTE || ctrl.ctrl_finished_block) begin
                            done  <= gnt;
                            state <= DONE;
                        end
                    end else if (ctrl.ctrl_finished_block) begin
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        wd <= wd_inc;
                        if (wd_inc == WD_MAX) begin
                            err   <= gnt;
                            state <= ERR;
                        end
                    end
                end
                DONE, ERR: begin
                    xfer_count <= byte_cnt;
                    gnt        <= '0;
                    state      <= DRAIN;
                end
                DRAIN: begin
                    if (!ctrl.ctrl_busy && ctrl.ctrl_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_scheduler.sv
// Directed bench for sd_block_scheduler: a scripted controller model streams bytes while
// each task checks grants, strobes, completion pulses, watchdog timing and reset behaviour.
module tb_sd_block_scheduler;

    localparam int NUM_REQ = 2;
    localparam int CNT_W   = 10;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    req_op;
    logic [32*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0]  req_wdata;
    logic [NUM_REQ-1:0]    gnt;
    logic [NUM_REQ-1:0]    rd_valid;
    logic [7:0]            rd_data;
    logic [NUM_REQ-1:0]    wr_ack;
    logic [NUM_REQ-1:0]    done;
    logic [NUM_REQ-1:0]    err;
    logic [CNT_W-1:0]      xfer_count;

    int checks;
    int errors;

    sd_block_scheduler_if ctrl_bus();

    sd_block_scheduler #(
        .NUM_REQ(NUM_REQ), .BLOCK_BYTES(512), .TIMEOUT_CYCLES(100), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_ack(wr_ack), .done(done), .err(err), .xfer_count(xfer_count), .ctrl(ctrl_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int bound, output int cycles, output logic [1:0] g);
        cycles = 0;
        while (gnt == 2'b00 && cycles < bound) begin
            step();
            cycles++;
        end
        g = gnt;
    endtask

    // Plays the controller from ISSUE to DRAIN; returns observations, the callers judge them.
    task automatic run_block(input int nbytes, input bit end_blk, input bit is_write,
                             input logic [1:0] mask,
                             output int n_strobe, output int n_bad, output int n_done_bad,
                             output logic [1:0] done_last, output int n_gnt_bad, output int n_exec);
        int       own;
        logic [1:0] strobe;
        logic [1:0] other;
        logic [7:0] exp_out;
        own = (mask == 2'b10) ? 1 : 0;
        n_strobe = 0; n_bad = 0; n_done_bad = 0; n_gnt_bad = 0; n_exec = 0;
        done_last = 2'b00;
        step();
        if (ctrl_bus.ctrl_execute) n_exec++;
        ctrl_bus.ctrl_busy = 1'b1;
        step();
        if (ctrl_bus.ctrl_execute) n_exec++;
        for (int i = 0; i < nbytes; i++) begin
            ctrl_bus.ctrl_finished_byte  = 1'b1;
            ctrl_bus.ctrl_incoming_byte  = 8'(i);
            ctrl_bus.ctrl_finished_block = end_blk && (i == nbytes - 1);
            if (is_write) begin
                #1;
                exp_out = own ? req_wdata[15:8] : req_wdata[7:0];
                if (ctrl_bus.ctrl_outgoing_byte !== exp_out) n_bad++;
            end
            step();
            strobe = is_write ? wr_ack : rd_valid;
            other  = is_write ? rd_valid : wr_ack;
            if (strobe == mask) n_strobe++;
            else n_bad++;
            if (other != 2'b00) n_bad++;
            if (!is_write && rd_data !== 8'(i)) n_bad++;
            if (is_write && wr_ack == mask) begin
                if (own == 1) req_wdata[15:8] = req_wdata[15:8] + 8'd1;
                else          req_wdata[7:0]  = req_wdata[7:0] + 8'd1;
            end
            if (gnt !== mask) n_gnt_bad++;
            if (i == nbytes - 1) done_last = done;
            else if (done != 2'b00 || err != 2'b00) n_done_bad++;
            ctrl_bus.ctrl_finished_byte  = 1'b0;
            ctrl_bus.ctrl_finished_block = 1'b0;
            if (i != nbytes - 1) begin
                step();
                if (rd_valid != 2'b00 || wr_ack != 2'b00) n_bad++;
                if (done != 2'b00 || err != 2'b00) n_done_bad++;
                if (gnt !== mask) n_gnt_bad++;
            end
        end
        step();
        ctrl_bus.ctrl_busy = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({gnt, rd_valid, wr_ack, done, err} !== 10'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0", {gnt, rd_valid, wr_ack, done, err});
        end
        checks++;
        if ({ctrl_bus.ctrl_execute, ctrl_bus.ctrl_op_code, ctrl_bus.ctrl_block_address} !== 34'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got exec %b op %b addr %h required 0", ctrl_bus.ctrl_execute,
                     ctrl_bus.ctrl_op_code, ctrl_bus.ctrl_block_address);
        end
        checks++;
        if (xfer_count !== '0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got xfer_count %0d rd_data %h required 0", xfer_count, rd_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        int n_strobe, n_bad, n_done_bad, n_gnt_bad, n_exec;
        logic [1:0] done_last;
        req_wdata = 16'h5A3C;
        req_addr[31:0] = 32'h0000_0010;
        req_op = 2'b00;
        req = 2'b01;
        #1;
        checks++;
        if (gnt !== 2'b00 || ctrl_bus.ctrl_outgoing_byte !== 8'h00) begin
            errors++;
            $display("FAIL read_pregrant: got gnt %b outgoing %h required 00 / 00", gnt,
                     ctrl_bus.ctrl_outgoing_byte);
        end
        step();
        checks++;
        if (gnt !== 2'b01 || ctrl_bus.ctrl_execute !== 1'b1) begin
            errors++;
            $display("FAIL read_grant: got gnt %b exec %b required 01 / 1", gnt, ctrl_bus.ctrl_execute);
        end
        checks++;
        if (ctrl_bus.ctrl_block_address !== 32'h10 || ctrl_bus.ctrl_op_code !== 1'b0) begin
            errors++;
            $display("FAIL read_latch: got addr %h op %b required 00000010 / 0",
                     ctrl_bus.ctrl_block_address, ctrl_bus.ctrl_op_code);
        end
        run_block(512, 1'b0, 1'b0, 2'b01, n_strobe, n_bad, n_done_bad, done_last, n_gnt_bad, n_exec);
        req = 2'b00;
        checks++;
        if (n_exec !== 0) begin
            errors++;
            $display("FAIL read_exec_single: got %0d extra execute cycles required 0", n_exec);
        end
        checks++;
        if (n_strobe !== 512 || n_bad !== 0) begin
            errors++;
            $display("FAIL read_bytes: got %0d strobes %0d bad required 512 / 0", n_strobe, n_bad);
        end
        checks++;
        if (done_last !== 2'b01 || n_done_bad !== 0) begin
            errors++;
            $display("FAIL read_done: got done %b early %0d required 01 / 0", done_last, n_done_bad);
        end
        checks++;
        if (gnt !== 2'b00 || xfer_count !== 10'd512 || n_gnt_bad !== 0) begin
            errors++;
            $display("FAIL read_end: got gnt %b xfer_count %0d gnt_bad %0d required 00 / 512 / 0",
                     gnt, xfer_count, n_gnt_bad);
        end
    endtask

    task automatic test_contention();
        int cyc, n_strobe, n_bad, n_done_bad, n_gnt_bad, n_exec;
        logic [1:0] g, exp_g, done_last;
        logic [31:0] exp_addr;
        #2;
        rst_n = 1'b0;
        step();
        req_addr = {32'h0000_0200, 32'h0000_0100};
        req_op = 2'b00;
        req = 2'b11;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
            wait_grant(10, cyc, g);
            checks++;
            if (g !== exp_g || ctrl_bus.ctrl_block_address !== exp_addr) begin
                errors++;
                $display("FAIL contention_order_%0d: got gnt %b addr %h required %b / %h", k, g,
                         ctrl_bus.ctrl_block_address, exp_g, exp_addr);
            end
            if (g == 2'b00) g = exp_g;
            run_block(512, 1'b0, 1'b0, g, n_strobe, n_bad, n_done_bad, done_last, n_gnt_bad, n_exec);
            checks++;
            if (n_strobe !== 512 || n_bad !== 0 || n_gnt_bad !== 0 || done_last !== exp_g) begin
                errors++;
                $display("FAIL contention_xfer_%0d: got strobes %0d bad %0d gnt_bad %0d done %b required 512/0/0/%b",
                         k, n_strobe, n_bad, n_gnt_bad, done_last, exp_g);
            end
        end
        req = 2'b00;
    endtask

    task automatic test_write();
        int cyc, n_strobe, n_bad, n_done_bad, n_gnt_bad, n_exec;
        logic [1:0] g, done_last;
        step();
        step();
        req_wdata[15:8] = 8'hA0;
        req_addr[63:32] = 32'h0000_2000;
        req_op = 2'b10;
        req = 2'b10;
        #1;
        checks++;
        if (ctrl_bus.ctrl_outgoing_byte !== 8'h00) begin
            errors++;
            $display("FAIL write_idle_outgoing: got %h required 00", ctrl_bus.ctrl_outgoing_byte);
        end
        wait_grant(10, cyc, g);
        checks++;
        if (g !== 2'b10 || ctrl_bus.ctrl_op_code !== 1'b1 || ctrl_bus.ctrl_block_address !== 32'h2000) begin
            errors++;
            $display("FAIL write_grant: got gnt %b op %b addr %h required 10 / 1 / 00002000", g,
                     ctrl_bus.ctrl_op_code, ctrl_bus.ctrl_block_address);
        end
        run_block(512, 1'b0, 1'b1, 2'b10, n_strobe, n_bad, n_done_bad, done_last, n_gnt_bad, n_exec);
        req = 2'b00;
        checks++;
        if (n_strobe !== 512 || n_bad !== 0) begin
            errors++;
            $display("FAIL write_bytes: got %0d wr_ack %0d bad required 512 / 0", n_strobe, n_bad);
        end
        checks++;
        if (done_last !== 2'b10 || n_done_bad !== 0 || xfer_count !== 10'd512) begin
            errors++;
            $display("FAIL write_done: got done %b early %0d xfer_count %0d required 10 / 0 / 512",
                     done_last, n_done_bad, xfer_count);
        end
    endtask

    task automatic test_timeout();
        int cyc, k, gnt_cycles, n_strobe, n_bad, n_done_bad, n_gnt_bad, n_exec;
        logic [1:0] g, errv, donev, done_last;
        step();
        step();
        req_addr[31:0] = 32'h30;
        req_op = 2'b00;
        req = 2'b01;
        wait_grant(10, cyc, g);
        ctrl_bus.ctrl_busy = 1'b1;
        errv = 2'b00;
        donev = 2'b00;
        for (k = 1; k <= 300; k++) begin
            step();
            donev = donev | done;
            if (err != 2'b00) begin
                errv = err;
                break;
            end
        end
        checks++;
        if (k !== 100 || errv !== 2'b01 || donev !== 2'b00) begin
            errors++;
            $display("FAIL timeout_err: got err %b after %0d cycles done %b required 01 after 100 / 00",
                     errv, k, donev);
        end
        step();
        checks++;
        if (gnt !== 2'b00 || xfer_count !== 10'd0) begin
            errors++;
            $display("FAIL timeout_release: got gnt %b xfer_count %0d required 00 / 0", gnt, xfer_count);
        end
        req = 2'b11;
        gnt_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt != 2'b00) gnt_cycles++;
        end
        checks++;
        if (gnt_cycles !== 0) begin
            errors++;
            $display("FAIL timeout_drain_hold: got %0d granted cycles while busy required 0", gnt_cycles);
        end
        ctrl_bus.ctrl_busy = 1'b0;
        wait_grant(10, cyc, g);
        checks++;
        if (g !== 2'b10) begin
            errors++;
            $display("FAIL timeout_regrant: got gnt %b required 10", g);
        end
        req = 2'b00;
        run_block(1, 1'b1, 1'b0, 2'b10, n_strobe, n_bad, n_done_bad, done_last, n_gnt_bad, n_exec);
        checks++;
        if (done_last !== 2'b10 || xfer_count !== 10'd1) begin
            errors++;
            $display("FAIL timeout_next_done: got done %b xfer_count %0d required 10 / 1", done_last, xfer_count);
        end
    endtask

    task automatic test_early_end();
        int cyc, n_strobe, n_bad, n_done_bad, n_gnt_bad, n_exec;
        logic [1:0] g, done_last;
        step();
        step();
        req_addr[31:0] = 32'h40;
        req_op = 2'b00;
        req = 2'b01;
        wait_grant(10, cyc, g);
        checks++;
        if (g !== 2'b01) begin
            errors++;
            $display("FAIL early_grant: got gnt %b required 01", g);
        end
        run_block(300, 1'b1, 1'b0, 2'b01, n_strobe, n_bad, n_done_bad, done_last, n_gnt_bad, n_exec);
        req = 2'b00;
        checks++;
        if (n_strobe !== 300 || n_bad !== 0 || n_done_bad !== 0) begin
            errors++;
            $display("FAIL early_bytes: got strobes %0d bad %0d early %0d required 300 / 0 / 0",
                     n_strobe, n_bad, n_done_bad);
        end
        checks++;
        if (done_last !== 2'b01 || xfer_count !== 10'd300) begin
            errors++;
            $display("FAIL early_done: got done %b xfer_count %0d required 01 / 300", done_last, xfer_count);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int cyc, bad_pulses;
        logic [1:0] g;
        step();
        step();
        req_wdata[15:8] = 8'h77;
        req_addr[63:32] = 32'h5000;
        req_op = 2'b10;
        req = 2'b10;
        wait_grant(10, cyc, g);
        step();
        ctrl_bus.ctrl_busy = 1'b1;
        step();
        for (int i = 0; i < 50; i++) begin
            ctrl_bus.ctrl_finished_byte = 1'b1;
            step();
            ctrl_bus.ctrl_finished_byte = 1'b0;
            step();
        end
        checks++;
        if (gnt !== 2'b10 || ctrl_bus.ctrl_outgoing_byte !== 8'h77) begin
            errors++;
            $display("FAIL midreset_pre: got gnt %b outgoing %h required 10 / 77", gnt,
                     ctrl_bus.ctrl_outgoing_byte);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, rd_valid, wr_ack, done, err} !== 10'b0 || ctrl_bus.ctrl_outgoing_byte !== 8'h00) begin
            errors++;
            $display("FAIL midreset_async: got strobes %b outgoing %h required 0 / 00",
                     {gnt, rd_valid, wr_ack, done, err}, ctrl_bus.ctrl_outgoing_byte);
        end
        checks++;
        if ({ctrl_bus.ctrl_execute, ctrl_bus.ctrl_op_code, ctrl_bus.ctrl_block_address} !== 34'b0 ||
            xfer_count !== '0 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL midreset_regs: got op %b addr %h xfer_count %0d rd_data %h required 0",
                     ctrl_bus.ctrl_op_code, ctrl_bus.ctrl_block_address, xfer_count, rd_data);
        end
        step();
        ctrl_bus.ctrl_busy = 1'b0;
        req = 2'b11;
        rst_n = 1'b1;
        bad_pulses = 0;
        cyc = 0;
        while (gnt == 2'b00 && cyc < 10) begin
            if (done != 2'b00 || err != 2'b00) bad_pulses++;
            step();
            cyc++;
        end
        checks++;
        if (gnt !== 2'b01 || bad_pulses !== 0) begin
            errors++;
            $display("FAIL midreset_next: got gnt %b done/err pulses %0d required 01 / 0", gnt, bad_pulses);
        end
        req = 2'b00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req = '0;
        req_op = '0;
        req_addr = '0;
        req_wdata = '0;
        ctrl_bus.ctrl_ready = 1'b1;
        ctrl_bus.ctrl_busy = 1'b0;
        ctrl_bus.ctrl_finished_byte = 1'b0;
        ctrl_bus.ctrl_finished_block = 1'b0;
        ctrl_bus.ctrl_incoming_byte = 8'h00;
        test_reset();
        test_single_read();
        test_contention();
        test_write();
        test_timeout();
        test_early_end();
        test_reset_mid_xfer();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_block_scheduler.md
Name: sd_block_scheduler

Overview:
Shares one SD card SPI block controller between NUM_REQ requesters, for example a boot loader and a user datapath.
Arbitrates round-robin and latches the winner's op and block address. Issues a single execute pulse to the controller, then routes per-byte strobes and data between the controller and the owner. Counts bytes, enforces a watchdog, and reports done or error per requester.
All logic runs on posedge clk. The controller's negedge-driven outputs are sampled on posedge.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BLOCK_BYTES, 512, data bytes per block transfer
TIMEOUT_CYCLES, 1000000, idle-cycle limit before abort
CNT_W, 10, byte counter width; must satisfy 2**CNT_W > BLOCK_BYTES

Ports:
clk  in  1  master clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester transfer request, level
req_op  in  NUM_REQ  per-requester op: 0 read, 1 write
req_addr  in  32*NUM_REQ  per-requester block address; slice i is bits [32*i+31:32*i]
req_wdata  in  8*NUM_REQ  per-requester write byte
gnt  out  NUM_REQ  one-hot owner, held for the whole transfer
rd_valid  out  NUM_REQ  one-cycle strobe: rd_data valid for that owner
rd_data  out  8  read byte
wr_ack  out  NUM_REQ  one-cycle strobe: owner's write byte consumed; present the next byte
done  out  NUM_REQ  one-cycle completion pulse
err  out  NUM_REQ  one-cycle timeout pulse
xfer_count  out  CNT_W  bytes moved in the last transfer
ctrl_ready  in  1  controller initialised and idle
ctrl_busy  in  1  controller busy
ctrl_finished_byte  in  1  controller byte done
ctrl_finished_block  in  1  controller block done
ctrl_incoming_byte  in  8  controller read byte
ctrl_execute  out  1  execute pulse to controller
ctrl_op_code  out  1  latched op
ctrl_block_address  out  32  latched block address
ctrl_outgoing_byte  out  8  req_wdata slice of owner (combinational mux by gnt)

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: gnt, rd_valid, wr_ack, done, err, ctrl_execute, ctrl_op_code, ctrl_block_address, xfer_count, rd_data.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - Reset mid-transfer aborts silently: no done or err pulse.
- States:
  - IDLE: if ctrl_ready && |req, pick the first set req searching from last+1 with wrap. Latch idx, op and addr into ctrl_op_code and ctrl_block_address; set gnt[idx]; clear byte_cnt and the watchdog; last <= idx. Next: ISSUE. Winner's gnt is asserted 1 cycle after req is seen.
  - ISSUE: ctrl_execute=1 for exactly this one cycle. Next: WAIT_BUSY.
  - WAIT_BUSY: ctrl_busy=1 -> XFER. Watchdog reaching TIMEOUT_CYCLES -> ERR.
  - XFER, on each ctrl_finished_byte:
    - byte_cnt++ and the watchdog clears.
    - Read: rd_data <= ctrl_incoming_byte; rd_valid[idx] pulses the next cycle.
    - Write: wr_ack[idx] pulses the next cycle.
  - XFER exit conditions:
    - ctrl_finished_byte while byte_cnt == BLOCK_BYTES-1 -> DONE.
    - ctrl_finished_block -> DONE. If it coincides with ctrl_finished_byte, the byte is counted and forwarded first.
    - Watchdog == TIMEOUT_CYCLES -> ERR.
  - DONE: done[idx]=1 for one cycle; xfer_count <= byte_cnt; gnt <= 0. Next: DRAIN.
  - ERR: err[idx]=1 for one cycle; xfer_count <= byte_cnt; gnt <= 0. Next: DRAIN.
  - DRAIN: wait for ctrl_busy==0 && ctrl_ready -> IDLE. No new grant while the controller is still active.
- Requester behaviour during a transfer:
  - Dropping req mid-transfer has no effect; the transfer runs to DONE or ERR.
  - req changes of other requesters are ignored until IDLE.
- The owner may re-request immediately after done. It wins only if no other requester is pending (round-robin fairness).
- ctrl_finished_byte outside XFER is ignored, with no strobe.
- Watchdog counts cycles since the last progress event: execute issued or a byte done. It saturates at TIMEOUT_CYCLES.
- ctrl_outgoing_byte is 0 when gnt == 0.

Test Plan:
- Single read: req=01, req_addr[0]=0x0000_0010, op=0; model streams 512 bytes 0x00..0xFF repeating. Expect gnt=01 one cycle after req; one ctrl_execute pulse with ctrl_block_address=0x10; 512 rd_valid[0] pulses with matching data; done[0] pulse; xfer_count=512.
- Contention: req=11 from reset. Expect requester 0 served first, then requester 1. With req=11 held again, expect the order 0,1,0,1; no gnt overlap, gnt never 11.
- Write: requester 1, op=1; req_wdata slice 1 advances on each wr_ack[1]. Expect ctrl_outgoing_byte to track slice 1; 512 wr_ack pulses; done[1].
- Timeout: model asserts ctrl_busy but sends no bytes, TIMEOUT_CYCLES=100. Expect err pulse 100 cycles after ISSUE and gnt dropped. Expect DRAIN held until ctrl_busy falls, then the next grant.
- Early block end: ctrl_finished_block coincident with byte 300. Expect byte 300 forwarded, then done and xfer_count=300.
- Reset mid-XFER at byte 50: all outputs 0 asynchronously, no done or err; the next request starts at requester 0.
